tt_sweep: RTL and testbench
===========================

TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4: cycles each input vector is held before sampling; legal range 1..255.
REQ-002 The block SHALL have parameters EXP_F and EXP_G, default 16'h0000 each: expected truth tables, used only when the check feature is compiled in.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a full 16-vector sweep.
REQ-006 a, b, c, d  output  1 each  stimulus to the downstream 4-input logic block; a is the MSB of the vector index, d the LSB.
REQ-007 f_in, g_in  input  1 each  responses returned by the downstream block.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse at sweep completion.
REQ-010 f_map, g_map  output  16 each  captured responses; bit i holds the response to vector i.
REQ-011 With TT_SWEEP_CHECK_EN defined, the block SHALL add err_cnt (output, 5 bits: mismatched vectors) and pass (output, 1 bit).

Function
REQ-012 The block SHALL implement four states: IDLE, DRIVE, SAMPLE and DONE.
REQ-013 IDLE: when start is high at a rising edge, the block SHALL enter DRIVE, set the index to 0, clear f_map and g_map, and load the hold counter.
REQ-014 DRIVE: {a,b,c,d} SHALL equal the index; the state SHALL last exactly HOLD_CYCLES cycles, then move to SAMPLE.
REQ-015 SAMPLE: {a,b,c,d} SHALL stay unchanged, and the block SHALL write f_in to f_map[index] and g_in to g_map[index] at the end of this one-cycle state.
REQ-016 On leaving SAMPLE, index 15 SHALL go to DONE; any other index SHALL increment and return to DRIVE.
REQ-017 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-018 busy SHALL be 1 in DRIVE and SAMPLE and 0 in IDLE and DONE.
REQ-019 Latency: with start sampled at edge k, done SHALL be high in the cycle starting at edge k+16*(HOLD_CYCLES+1).
REQ-020 start SHALL be ignored in DRIVE, SAMPLE and DONE; a start held high through DONE SHALL launch a new sweep from the following IDLE cycle.
REQ-021 In IDLE, {a,b,c,d} SHALL be 4'b0000, and f_map and g_map SHALL keep their last sweep values.
REQ-022 The index SHALL be 4 bits and SHALL never wrap within a sweep; the 15-to-0 transition occurs only through DONE, IDLE and start.

Reset
REQ-023 Asserting rst, including mid-sweep, SHALL immediately force the following: state IDLE; index 0; a, b, c and d at 0; busy and done at 0; f_map and g_map at 0; err_cnt 0 and pass 0.
REQ-024 After rst is released, the block SHALL wait for a new start and SHALL NOT resume a partial sweep.

Configuration
REQ-025 The block SHALL have macro TT_SWEEP_CHECK_EN.
- Defined: each SAMPLE compares f_in with EXP_F[index] and g_in with EXP_G[index]; err_cnt increments once per vector if either differs.
- Defined: err_cnt is cleared on start acceptance and saturates at 16.
- Defined: pass is set in DONE if err_cnt is 0 and holds until the next start or rst.
- Not defined: err_cnt and pass ports are absent, and no comparison logic is built.

Structure
REQ-026 Shared package tt_pkg SHALL hold:
- the state encoding (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3);
- NUM_VEC=16;
- IDX_W=4;
- HOLD_W=8.
REQ-027 The block SHALL contain one sub-module, tt_hold_timer: a loadable down-counter of width HOLD_W that flags expiry to the FSM.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Full sweep: HOLD_CYCLES=2, downstream model f=a&b, g=c|d, pulse start -> done exactly 48 cycles after start edge, f_map=16'hF000, g_map=16'hEEEE, busy high for 48 cycles.
- Vector order: with HOLD_CYCLES=1, the {a,b,c,d} sequence observed on successive SAMPLE cycles SHALL be 0,1,2,...,15.
- Start while busy: start pulsed at vector 5 -> ignored, sweep completes normally, done pulses once.
- Reset mid-sweep: rst asserted at vector 9 -> busy=0, f_map=g_map=0, outputs 0 immediately; a new start gives a full, correct sweep.
- Back-to-back: start held high continuously -> two sweeps with exactly one IDLE cycle between done and the next DRIVE; maps are cleared at the second start.
- With TT_SWEEP_CHECK_EN: EXP_F=16'hF000, EXP_G=16'hEEEE, and the model with g inverted on vector 3 -> err_cnt=1, pass=0; with the model corrected -> err_cnt=0, pass=1.

Source files
------------

// File: rtl/tt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tt_pkg
// Brief   : Shared state encoding and sizing constants for the truth-table
//           sweeper.
// Rev     : 1.0 - initial release
// ============================================================================
package tt_pkg;

    localparam int NUM_VEC = 16;
    localparam int IDX_W   = 4;
    localparam int HOLD_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_VEC - 1);

    // The timer expires at zero, so a hold of N cycles loads N-1.
    function automatic logic [HOLD_W-1:0] hold_load(input int cycles);
        return HOLD_W'(cycles - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_sweep_if.sv
`default_nettype none
// ============================================================================
// Module  : tt_sweep_if
// Brief   : Control, stimulus/response and result bundle of tt_sweep.
//           err_cnt/pass exist only with TT_SWEEP_CHECK_EN defined.
// Rev     : 1.0 - initial release
// ============================================================================
interface tt_sweep_if;
    import tt_pkg::*;

    logic               start;
    logic               a;
    logic               b;
    logic               c;
    logic               d;
    logic               f_in;
    logic               g_in;
    logic               busy;
    logic               done;
    logic [NUM_VEC-1:0] f_map;
    logic [NUM_VEC-1:0] g_map;
`ifdef TT_SWEEP_CHECK_EN
    logic [4:0]         err_cnt;
    logic               pass;
`endif

    // master = the sweeper, slave = the environment around it
    modport master (
        input  start,
        input  f_in,
        input  g_in,
        output a,
        output b,
        output c,
        output d,
        output busy,
        output done,
        output f_map,
        output g_map
`ifdef TT_SWEEP_CHECK_EN
        ,
        output err_cnt,
        output pass
`endif
    );

    modport slave (
        output start,
        output f_in,
        output g_in,
        input  a,
        input  b,
        input  c,
        input  d,
        input  busy,
        input  done,
        input  f_map,
        input  g_map
`ifdef TT_SWEEP_CHECK_EN
        ,
        input  err_cnt,
        input  pass
`endif
    );

endinterface
`default_nettype wire

// File: rtl/tt_hold_timer.sv
`default_nettype none
// ============================================================================
// Module  : tt_hold_timer
// Brief   : Loadable down-counter; o_expired is high while the count is zero.
// Rev     : 1.0 - initial release
// ============================================================================
module tt_hold_timer
    import tt_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic [HOLD_W-1:0] i_load_val,
    output logic                   o_expired
);

    logic [HOLD_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/tt_sweep.sv
`default_nettype none
// ============================================================================
// Module  : tt_sweep
// Brief   : Drives all 16 input vectors into a 4-input block and captures its
//           two responses. Optional golden compare: TT_SWEEP_CHECK_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module tt_sweep
    import tt_pkg::*;
#(
    parameter int                 HOLD_CYCLES = 4,
    parameter logic [NUM_VEC-1:0] EXP_F       = 16'h0000,
    parameter logic [NUM_VEC-1:0] EXP_G       = 16'h0000
)
(
    input  wire logic  clk,
    input  wire logic  rst,
    tt_sweep_if.master bus
);

    localparam logic [HOLD_W-1:0] c_HOLD_LOAD = hold_load(HOLD_CYCLES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [NUM_VEC-1:0] r_f_map;
    logic [NUM_VEC-1:0] r_g_map;
    logic               w_load;
    logic               w_expired;
    logic               w_accept;
    logic               w_vec_en;

    tt_hold_timer u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (c_HOLD_LOAD),
        .o_expired  (w_expired)
    );

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_vec_en = (r_state == DRIVE) || (r_state == SAMPLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = DRIVE;
                    w_load      = 1'b1;
                end
            end
            DRIVE: begin
                if (w_expired) begin
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = DRIVE;
                    w_load      = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Index stops at the last vector; only a new start rewinds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_f_map <= '0;
            r_g_map <= '0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_f_map <= '0;
            r_g_map <= '0;
        end else if (r_state == SAMPLE) begin
            r_f_map[r_idx] <= bus.f_in;
            r_g_map[r_idx] <= bus.g_in;
            if (r_idx != c_LAST_IDX) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign {bus.a, bus.b, bus.c, bus.d} = w_vec_en ? r_idx : '0;
    assign bus.busy  = w_vec_en;
    assign bus.done  = (r_state == DONE);
    assign bus.f_map = r_f_map;
    assign bus.g_map = r_g_map;

`ifdef TT_SWEEP_CHECK_EN
    localparam logic [4:0] c_ERR_MAX = 5'd16;

    logic [4:0] r_err_cnt;
    logic       r_pass;
    logic       w_mismatch;

    assign w_mismatch = (bus.f_in != EXP_F[r_idx]) || (bus.g_in != EXP_G[r_idx]);

    // pass is decided on the last SAMPLE so it is already valid during DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
        end else if (w_accept) begin
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
        end else if (r_state == SAMPLE) begin
            if (w_mismatch && (r_err_cnt != c_ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (r_idx == c_LAST_IDX) begin
                r_pass <= (r_err_cnt == '0) && !w_mismatch;
            end
        end
    end

    assign bus.err_cnt = r_err_cnt;
    assign bus.pass    = r_pass;
`else
    logic w_unused_exp;
    assign w_unused_exp = ^{EXP_F, EXP_G};
`endif

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep.sv
`default_nettype none
// ============================================================================
// Module  : tb_tt_sweep
// Brief   : Self-checking bench for tt_sweep (HOLD_CYCLES 2 and 1 instances).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_tt_sweep;

    logic clk;
    logic rst;
    logic start;
    logic inj;
    int   n_cmp;
    int   n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ref_f(input int v);
        return (v >= 12);
    endfunction

    function automatic logic ref_g(input int v);
        return ((v % 4) != 0) ^ (inj && (v == 3));
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int H     = (gi == 0) ? 2 : 1;
        localparam int SWEEP = 16 * (H + 1);

        tt_sweep_if bus ();

        assign bus.start = start;
        assign bus.f_in  = bus.a & bus.b;
        assign bus.g_in  = (bus.c | bus.d) ^ (inj && ({bus.a, bus.b, bus.c, bus.d} == 4'd3));

        tt_sweep #(
            .HOLD_CYCLES (H),
            .EXP_F       (16'hF000),
            .EXP_G       (16'hEEEE)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // m_t counts cycles since the first DRIVE cycle; SWEEP is the done cycle.
        bit          m_run;
        int          m_t;
        logic [15:0] m_f;
        logic [15:0] m_g;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_run <= 1'b0;
                m_t   <= 0;
                m_f   <= '0;
                m_g   <= '0;
            end else if (m_run) begin
                if (m_t == SWEEP) begin
                    m_run <= 1'b0;
                end else begin
                    if ((m_t % (H + 1)) == H) begin
                        m_f[m_t / (H + 1)] <= ref_f(m_t / (H + 1));
                        m_g[m_t / (H + 1)] <= ref_g(m_t / (H + 1));
                    end
                    m_t <= m_t + 1;
                end
            end else if (start) begin
                m_run <= 1'b1;
                m_t   <= 0;
                m_f   <= '0;
                m_g   <= '0;
            end
        end

        always @(negedge clk) begin
            logic e_busy;
            e_busy = m_run && (m_t < SWEEP);
            check($sformatf("h%0d_busy", H), 32'(bus.busy), 32'(e_busy));
            check($sformatf("h%0d_done", H), 32'(bus.done), 32'(m_run && (m_t == SWEEP)));
            check($sformatf("h%0d_vec", H), 32'({bus.a, bus.b, bus.c, bus.d}),
                  e_busy ? 32'(m_t / (H + 1)) : 32'd0);
            check($sformatf("h%0d_f_map", H), 32'(bus.f_map), 32'(m_f));
            check($sformatf("h%0d_g_map", H), 32'(bus.g_map), 32'(m_g));
        end
    end

    logic        d2_busy, d2_done, d1_busy;
    logic [3:0]  d2_vec, d1_vec;
    logic [15:0] d2_f, d2_g;
    assign d2_busy = g_inst[0].bus.busy;
    assign d2_done = g_inst[0].bus.done;
    assign d2_vec  = {g_inst[0].bus.a, g_inst[0].bus.b, g_inst[0].bus.c, g_inst[0].bus.d};
    assign d2_f    = g_inst[0].bus.f_map;
    assign d2_g    = g_inst[0].bus.g_map;
    assign d1_busy = g_inst[1].bus.busy;
    assign d1_vec  = {g_inst[1].bus.a, g_inst[1].bus.b, g_inst[1].bus.c, g_inst[1].bus.d};

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_vec(input logic [3:0] v, input string name);
        int k;
        k = 0;
        while (!(d2_busy && d2_vec == v) && k < 200) begin
            step();
            k++;
        end
        check(name, 32'(k < 200), 32'd1);
    endtask

    // Returns in the done cycle of the HOLD_CYCLES=2 instance.
    task automatic full_sweep(input logic [15:0] exp_g);
        int cnt, nb, t1;
        pulse_start();
        cnt = 0;
        nb  = 0;
        t1  = 0;
        while (!d2_done && cnt < 200) begin
            if (d2_busy) nb++;
            if (d1_busy) begin
                if (t1 % 2 == 1) check("vec_order", 32'(d1_vec), 32'(t1 / 2));
                t1++;
            end
            step();
            cnt++;
        end
        check("done_latency", cnt, 48);
        check("busy_cycles", nb, 48);
        check("h1_busy_cycles", t1, 32);
        check("f_map", 32'(d2_f), 32'h0000F000);
        check("g_map", 32'(d2_g), 32'(exp_g));
        step();
        check("done_one_cycle", 32'(d2_done), 32'd0);
        check("idle_vec", 32'(d2_vec), 32'd0);
    endtask

    initial begin
        int ndone, nidle;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        inj    = 1'b0;
        repeat (3) step();
        check("rst_busy", 32'(d2_busy), 32'd0);
        check("rst_done", 32'(d2_done), 32'd0);
        check("rst_maps", 32'({d2_f, d2_g}), 32'd0);
        rst = 1'b0;
        repeat (2) step();

        full_sweep(16'hEEEE);
        repeat (3) step();
        check("maps_hold_idle", 32'({d2_f, d2_g}), 32'hF000EEEE);

        // start while busy
        pulse_start();
        wait_vec(4'd5, "reach_vec5");
        start = 1'b1;
        step();
        start = 1'b0;
        ndone = 0;
        repeat (80) begin
            if (d2_done) ndone++;
            step();
        end
        check("done_pulses", ndone, 1);
        check("busy_sweep_f", 32'(d2_f), 32'h0000F000);
        check("busy_sweep_g", 32'(d2_g), 32'h0000EEEE);

        // reset mid-sweep
        pulse_start();
        wait_vec(4'd9, "reach_vec9");
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(d2_busy), 32'd0);
        check("midrst_vec", 32'(d2_vec), 32'd0);
        check("midrst_maps", 32'({d2_f, d2_g}), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        repeat (4) step();
        check("no_resume", 32'(d2_busy), 32'd0);
        full_sweep(16'hEEEE);
        repeat (3) step();

        // back-to-back with start held high
        start = 1'b1;
        ndone = 0;
        while (!d2_done && ndone < 200) begin
            step();
            ndone++;
        end
        check("b2b_first_done", 32'(d2_done), 32'd1);
        step();
        nidle = 0;
        while (!d2_busy && nidle < 10) begin
            nidle++;
            step();
        end
        check("b2b_idle_gap", nidle, 1);
        check("b2b_maps_cleared", 32'({d2_f, d2_g}), 32'd0);
        start = 1'b0;
        ndone = 0;
        while (!d2_done && ndone < 200) begin
            step();
            ndone++;
        end
        check("b2b_second_done", 32'(d2_done), 32'd1);
        check("b2b_f_map", 32'(d2_f), 32'h0000F000);
        check("b2b_g_map", 32'(d2_g), 32'h0000EEEE);
        repeat (60) step();

`ifdef TT_SWEEP_CHECK_EN
        inj = 1'b1;
        full_sweep(16'hEEE6);
        check("err_cnt_bad", 32'(g_inst[0].bus.err_cnt), 32'd1);
        check("pass_bad", 32'(g_inst[0].bus.pass), 32'd0);
        repeat (3) step();
        inj = 1'b0;
        full_sweep(16'hEEEE);
        check("err_cnt_good", 32'(g_inst[0].bus.err_cnt), 32'd0);
        check("pass_good", 32'(g_inst[0].bus.pass), 32'd1);
        check("h1_pass_good", 32'(g_inst[1].bus.pass), 32'd1);
        repeat (3) step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
